// File: rtl/pipe_reg.sv
// Valid/ready pipeline register with optional two-entry skid buffer.
// Define PIPE_REG_SKID_EN for the skid build (registered in_ready); default is a single-entry stage.
module pipe_reg #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // State encoding doubles as the beat count
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
`ifdef PIPE_REG_SKID_EN
  localparam logic [1:0] S_FULL  = 2'd2;
`endif

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_nxt;
  logic             out_valid_q;
  logic [1:0]       occupancy_q;
  logic             accept;
  logic             fire;

`ifdef PIPE_REG_SKID_EN
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_nxt;
  logic             in_ready_q;

  assign in_ready = in_ready_q;
`else
  // Single-entry stage can take a beat whenever the held one leaves this cycle
  assign in_ready = (!out_valid_q || out_ready) && !reset;
`endif

  assign accept    = in_valid && in_ready;
  assign fire      = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occupancy_q;

  // Next-state and datapath selection; flush wins over any handshake
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
`ifdef PIPE_REG_SKID_EN
    skid_nxt  = skid_q;
`endif
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            state_nxt = S_ONE;
            main_nxt  = in_data;
          end
        end
        S_ONE: begin
          if (accept && fire) begin
            main_nxt = in_data;
          end else if (fire) begin
            state_nxt = S_EMPTY;
`ifdef PIPE_REG_SKID_EN
          end else if (accept) begin
            state_nxt = S_FULL;
            skid_nxt  = in_data;
`endif
          end
        end
`ifdef PIPE_REG_SKID_EN
        S_FULL: begin
          if (fire) begin
            state_nxt = S_ONE;
            main_nxt  = skid_q;
          end
        end
`endif
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_EMPTY;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
      main_q      <= RESET_VAL;
`ifdef PIPE_REG_SKID_EN
      skid_q      <= RESET_VAL;
      in_ready_q  <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      out_valid_q <= (state_nxt != S_EMPTY);
      occupancy_q <= state_nxt;
      main_q      <= main_nxt;
`ifdef PIPE_REG_SKID_EN
      skid_q      <= skid_nxt;
      in_ready_q  <= (state_nxt != S_FULL);
`endif
    end
  end

endmodule

// File: tb/tb_pipe_reg.sv
// Scoreboard bench for pipe_reg: directed scenarios then biased random traffic.
// Works for both the default and the PIPE_REG_SKID_EN build.
module tb_pipe_reg;

  localparam int unsigned      W  = 16;
  localparam logic [W-1:0]     RV = 16'hFFFF;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  always #5 clk = ~clk;

  pipe_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Reference model: ordered list of beats held, plus the expected in_ready
  logic [W-1:0] exp_q[$];
  bit           pend;
  bit           mdl_ready;
  bit           rst_flag;
  bit           chk_en;
  int           n_checks;
  int           n_err;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs and record any beat the model says will be accepted
  task automatic drive(input bit v, input logic [W-1:0] d, input bit ordy, input bit fl, input bit rs);
    bit acc;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
`ifndef PIPE_REG_SKID_EN
    mdl_ready = ((exp_q.size() == 0) || ordy) && !rs;
`endif
    acc  = v && mdl_ready && !fl && !rs;
    pend = acc;
    if (acc) exp_q.push_back(d);
  endtask

  // Monitor: compare outputs mid-cycle, then retire beats for the coming edge
  always @(negedge clk) begin : mon
    int held;
    if (chk_en) begin
      held = exp_q.size() - (pend ? 1 : 0);
      chk("occupancy", W'(occupancy), W'(held));
      chk("out_valid", W'(out_valid), W'(held != 0));
      chk("in_ready", W'(in_ready), W'(mdl_ready));
      if (held != 0)
        chk("out_data", out_data, exp_q[0]);
      else if (rst_flag)
        chk("reset_data", out_data, RV);

      if (reset) begin
        exp_q.delete();
        rst_flag = 1'b1;
`ifdef PIPE_REG_SKID_EN
        mdl_ready = 1'b0;
`endif
      end else if (flush) begin
        exp_q.delete();
`ifdef PIPE_REG_SKID_EN
        mdl_ready = 1'b1;
`endif
      end else begin
        if (held != 0 && out_ready) void'(exp_q.pop_front());
`ifdef PIPE_REG_SKID_EN
        mdl_ready = (exp_q.size() < 2);
`endif
        if (exp_q.size() != 0) rst_flag = 1'b0;
      end
    end
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    pend      = 1'b0;
    mdl_ready = 1'b0;
    rst_flag  = 1'b1;
    chk_en    = 1'b0;
    n_checks  = 0;
    n_err     = 0;

    // Reset, then release
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream with downstream always ready
    for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Stall downstream with two beats offered, then drain
    drive(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Flush while full, colliding with a new beat and a fire
    drive(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Reset colliding with flush and handshakes while one beat is held
    drive(1'b1, 16'h4321, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h5678, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Random traffic with per-block bias on valid and ready
    for (int blk = 0; blk < 12; blk++) begin
      int pv;
      int pr;
      pv = int'($urandom_range(1, 4));
      pr = int'($urandom_range(1, 4));
      for (int i = 0; i < 200; i++)
        drive(int'($urandom_range(0, 4)) < pv, W'($urandom), int'($urandom_range(0, 4)) < pr,
              $urandom_range(0, 40) == 0, $urandom_range(0, 80) == 0);
    end

    // Drain
    for (int i = 0; i < 4; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits (≥1).
REQ-002 Parameter RESET_VAL, default {WIDTH{1'b0}}, value loaded into all data storage on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous pipeline flush, discards held beats.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  beat presented downstream.
REQ-010 out_ready  input  1  downstream accepts a beat this cycle.
REQ-011 out_data  output  WIDTH  downstream payload, driven from the main register.
REQ-012 occupancy  output  2  number of beats held (0, 1 or 2).

Function
REQ-013 Accept = in_valid && in_ready; fire = out_valid && out_ready; both are evaluated at the same rising edge.
REQ-014 States EMPTY (occupancy 0), ONE (1), FULL (2); out_valid SHALL be 1 exactly in ONE and FULL.
REQ-015 EMPTY: accept -> ONE, main <= in_data; otherwise hold.
REQ-016 ONE: accept && fire -> ONE, main <= in_data; accept only -> FULL, skid <= in_data; fire only -> EMPTY; neither -> hold.
REQ-017 FULL: fire -> ONE, main <= skid; no accept is possible (in_ready = 0).
REQ-018 in_ready SHALL be a registered flag: 0 in the cycle after reset is asserted; otherwise 1 iff next state is not FULL.
REQ-019 While out_valid && !out_ready, out_data and out_valid SHALL remain stable.
REQ-020 Beats SHALL leave in acceptance order; none duplicated or dropped except by flush/reset.
REQ-021 flush (reset low) SHALL force next state EMPTY and override any accept or fire in the same cycle; the accepted beat in that cycle is discarded; main/skid data are left unchanged; in_ready is 1 the next cycle.
REQ-022 Latency: an accepted beat appears on out_data with out_valid the cycle after the accept when the block was EMPTY or fired that cycle.
REQ-023 Throughput: one beat per cycle sustained when out_ready is held high.

Reset
REQ-024 reset has priority over flush and all handshakes.
REQ-025 On reset: state EMPTY, out_valid 0, occupancy 0, in_ready 0, main and skid <= RESET_VAL, so out_data = RESET_VAL.
REQ-026 Reset asserted mid-transfer SHALL discard all held beats; in_ready returns to 1 the cycle after reset deasserts.

Configuration
REQ-027 Macro PIPE_REG_SKID_EN defined: two-entry skid behaviour of REQ-014..REQ-018, in_ready purely registered.
REQ-028 Macro not defined: skid register and FULL state SHALL be removed; in_ready = (!out_valid || out_ready) && !reset (combinational); occupancy never exceeds 1; REQ-015/016 apply with accept-only in ONE impossible.

Verification
REQ-029 reset for 1 cycle with RESET_VAL=16'hFFFF -> out_data=16'hFFFF, out_valid=0, occupancy=0, in_ready=0; in_ready=1 the cycle after deassert.
REQ-030 out_ready=1, in_valid=1 with 16'h0001..16'h0008 on consecutive cycles -> same values on out_data on consecutive cycles, one cycle after each accept, no bubbles.
REQ-031 (SKID_EN) out_ready=0, send 16'hAAAA then 16'h5555 -> occupancy=2, in_ready=0, out_data=16'hAAAA held stable; raise out_ready -> 16'hAAAA then 16'h5555 out; in_ready=1 the cycle after the first fire.
REQ-032 occupancy=2, assert flush together with out_ready=1 and in_valid=1 (16'h1234) -> next cycle occupancy=0, out_valid=0, 16'h1234 never appears on the output.
REQ-033 occupancy=1, assert reset together with flush, in_valid and out_ready -> next cycle out_data=RESET_VAL, out_valid=0, occupancy=0, in_ready=0.
REQ-034 (no SKID_EN) out_ready=0, out_valid=1 -> in_ready=0 combinationally; raise out_ready -> in_ready=1 in the same cycle; occupancy never reads 2.
